// File: rtl/sb_cfg_pkg.sv
// Shared types and routing helper for the configurable switch block.
// The optional parity check is enabled by defining SB_CFG_PARITY_EN.
package sb_cfg_pkg;

    typedef enum logic [1:0] {
        SB_IDLE   = 2'd0,
        SB_SHIFT  = 2'd1,
        SB_COMMIT = 2'd2
    } sb_cfg_state_e;

    localparam int SIDE_TOP    = 0;
    localparam int SIDE_RIGHT  = 1;
    localparam int SIDE_BOTTOM = 2;
    localparam int SIDE_LEFT   = 3;
    localparam int NUM_SIDES   = SIDE_LEFT + 1;

    // Flat chan_in index feeding mux input k of output (s,t).
    function automatic int sb_mux_src(input int s, input int t, input int k, input int chan_width);
        return ((s + 1 + (k % 3)) % NUM_SIDES) * chan_width + ((t + k / 3) % chan_width);
    endfunction

endpackage

// File: rtl/sb_cfg_switch_block_track_mux.sv
// One output track: MUX_SIZE-input mux gated by the field's enable bit.
// Out-of-range selects drive 0.
module sb_cfg_track_mux #(
    parameter int MUX_SIZE = 4,
    parameter int SEL_BITS = 2
) (
    input  logic [SEL_BITS:0]   i_fld,
    input  logic [MUX_SIZE-1:0] i_srcs,
    output logic                o_out
);

    logic                w_en;
    logic [SEL_BITS-1:0] w_sel;

    assign w_en  = i_fld[SEL_BITS];
    assign w_sel = i_fld[SEL_BITS-1:0];

    always_comb begin
        o_out = 1'b0;
        for (int k = 0; k < MUX_SIZE; k++) begin
            if (w_en && (w_sel == SEL_BITS'(k))) begin
                o_out = i_srcs[k];
            end
        end
    end

endmodule

// File: rtl/sb_cfg_switch_block.sv
// Generic switch block with a shadowed, atomically committed config chain.
// Define SB_CFG_PARITY_EN to append an even-parity bit and expose cfg_err.
module sb_cfg_switch_block
    import sb_cfg_pkg::*;
#(
    parameter int CHAN_WIDTH = 5,
    parameter int MUX_SIZE   = 4,
    parameter int SEL_BITS   = $clog2(MUX_SIZE)
) (
    input  logic                    prog_clk,
    input  logic                    pReset,
    input  logic                    ccff_head,
    input  logic                    ccff_en,
    input  logic [4*CHAN_WIDTH-1:0] chan_in,
    output logic [4*CHAN_WIDTH-1:0] chan_out,
    output logic                    ccff_tail,
    output logic                    cfg_done,
    output logic                    cfg_valid,
`ifdef SB_CFG_PARITY_EN
    output logic                    cfg_err,
`endif
    output sb_cfg_state_e           o_dbg_state
);

    localparam int FLD      = SEL_BITS + 1;
    localparam int NUM_OUT  = 4 * CHAN_WIDTH;
    localparam int CFG_BITS = NUM_OUT * FLD;
`ifdef SB_CFG_PARITY_EN
    localparam int LOAD_BITS = CFG_BITS + 1;
`else
    localparam int LOAD_BITS = CFG_BITS;
`endif
    localparam int CNT_W = $clog2(LOAD_BITS + 1);

    sb_cfg_state_e        r_state;
    sb_cfg_state_e        w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [LOAD_BITS-1:0] r_shadow;
    logic [CFG_BITS-1:0]  r_active;
    logic                 r_cfg_valid;
    logic                 w_shift;
    logic                 w_par_ok;
    logic                 w_commit_ok;
    logic [CFG_BITS-1:0]  w_shadow_cfg;
    logic [CFG_BITS-1:0]  w_cfg_view;

`ifdef SB_CFG_PARITY_EN
    logic r_cfg_err;
    assign w_shadow_cfg = r_shadow[CFG_BITS:1];
    assign w_par_ok     = ~(^r_shadow);
    assign cfg_err      = r_cfg_err;
`else
    assign w_shadow_cfg = r_shadow[CFG_BITS-1:0];
    assign w_par_ok     = 1'b1;
`endif

    assign w_commit_ok = (r_state == SB_COMMIT) && w_par_ok;
    // The committing bitstream drives routing during COMMIT so that chan_out
    // changes in the same cycle cfg_done pulses; active catches up at the edge.
    assign w_cfg_view  = w_commit_ok ? w_shadow_cfg : r_active;

    assign ccff_tail   = r_shadow[LOAD_BITS-1];
    assign cfg_valid   = r_cfg_valid;
    assign o_dbg_state = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift     = 1'b0;
        cfg_done    = 1'b0;
        case (r_state)
            SB_IDLE: begin
                if (ccff_en) begin
                    w_shift     = 1'b1;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = SB_SHIFT;
                end
            end
            SB_SHIFT: begin
                if (ccff_en) begin
                    w_shift   = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(LOAD_BITS - 1)) begin
                        w_state_nxt = SB_COMMIT;
                    end
                end
            end
            SB_COMMIT: begin
                cfg_done    = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = SB_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = SB_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            r_state     <= SB_IDLE;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_active    <= '0;
            r_cfg_valid <= 1'b0;
`ifdef SB_CFG_PARITY_EN
            r_cfg_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_shift) begin
                r_shadow <= {r_shadow[LOAD_BITS-2:0], ccff_head};
            end
            if (w_commit_ok) begin
                r_active    <= w_shadow_cfg;
                r_cfg_valid <= 1'b1;
            end
`ifdef SB_CFG_PARITY_EN
            if (r_state == SB_COMMIT) begin
                r_cfg_err <= ~w_par_ok;
            end
`endif
        end
    end

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
        logic [MUX_SIZE-1:0] w_srcs;
        for (genvar k = 0; k < MUX_SIZE; k++) begin : g_src
            localparam int SRC = sb_mux_src(o / CHAN_WIDTH, o % CHAN_WIDTH, k, CHAN_WIDTH);
            assign w_srcs[k] = chan_in[SRC];
        end
        sb_cfg_track_mux #(
            .MUX_SIZE (MUX_SIZE),
            .SEL_BITS (SEL_BITS)
        ) u_mux (
            .i_fld  (w_cfg_view[o*FLD +: FLD]),
            .i_srcs (w_srcs),
            .o_out  (chan_out[o])
        );
    end

endmodule

// File: tb/tb_sb_cfg_switch_block.sv
// Randomised and directed bench for sb_cfg_switch_block against a routing model.
// Build with SB_CFG_PARITY_EN defined to exercise the parity variant.
`timescale 1ns/1ps
module tb_sb_cfg_switch_block;
  import sb_cfg_pkg::*;

  localparam int CW   = 5;
  localparam int MUX  = 4;
  localparam int FLD  = 3;
  localparam int NOUT = 4 * CW;
  localparam int CFGB = NOUT * FLD;
`ifdef SB_CFG_PARITY_EN
  localparam int LOADB = CFGB + 1;
`else
  localparam int LOADB = CFGB;
`endif

  logic            prog_clk = 1'b0;
  logic            pReset = 1'b0;
  logic            ccff_head = 1'b0;
  logic            ccff_en = 1'b0;
  logic [NOUT-1:0] chan_in = '0;
  logic [NOUT-1:0] chan_out;
  logic            ccff_tail;
  logic            cfg_done;
  logic            cfg_valid;
  sb_cfg_state_e   dbg_state;
`ifdef SB_CFG_PARITY_EN
  logic            cfg_err;
`endif

  int chk_cnt = 0;
  int pass_cnt = 0;
  bit cmp_on = 1'b0;

  // clock / reset
  always #5 prog_clk = ~prog_clk;

  sb_cfg_switch_block #(
    .CHAN_WIDTH (CW),
    .MUX_SIZE   (MUX)
  ) dut (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .ccff_head   (ccff_head),
    .ccff_en     (ccff_en),
    .chan_in     (chan_in),
    .chan_out    (chan_out),
    .ccff_tail   (ccff_tail),
    .cfg_done    (cfg_done),
    .cfg_valid   (cfg_valid),
`ifdef SB_CFG_PARITY_EN
    .cfg_err     (cfg_err),
`endif
    .o_dbg_state (dbg_state)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endfunction

  // behavioural model: bit history, accepted-bit count, committed fields
  logic [LOADB-1:0] m_shadow = '0;
  logic [CFGB-1:0]  m_active = '0;
  int               m_cnt = 0;
  bit               m_commit = 1'b0;
  bit               m_valid = 1'b0;
  bit               m_err = 1'b0;

  function automatic logic [CFGB-1:0] model_cfg(input logic [LOADB-1:0] sh);
`ifdef SB_CFG_PARITY_EN
    return sh[CFGB:1];
`else
    return sh[CFGB-1:0];
`endif
  endfunction

  function automatic bit model_par_ok(input logic [LOADB-1:0] sh);
`ifdef SB_CFG_PARITY_EN
    return (^sh) == 1'b0;
`else
    return sh[0] | ~sh[0];
`endif
  endfunction

  function automatic logic [NOUT-1:0] model_route(input logic [CFGB-1:0] cfg, input logic [NOUT-1:0] cin);
    logic [NOUT-1:0] r;
    int s, t, sel, side, trk;
    r = '0;
    for (int o = 0; o < NOUT; o++) begin
      s = o / CW;
      t = o % CW;
      sel = int'(cfg[o*FLD +: 2]);
      side = (s + 1 + sel % 3) % 4;
      trk = (t + sel / 3) % CW;
      if (cfg[o*FLD + 2] && sel < MUX) r[o] = cin[side*CW + trk];
    end
    return r;
  endfunction

  always @(posedge prog_clk) begin
    if (!pReset) begin
      m_shadow <= '0;
      m_active <= '0;
      m_cnt <= 0;
      m_commit <= 1'b0;
      m_valid <= 1'b0;
      m_err <= 1'b0;
    end else if (m_commit) begin
      if (model_par_ok(m_shadow)) begin
        m_active <= model_cfg(m_shadow);
        m_valid <= 1'b1;
        m_err <= 1'b0;
      end else begin
        m_err <= 1'b1;
      end
      m_commit <= 1'b0;
    end else if (ccff_en) begin
      m_shadow <= {m_shadow[LOADB-2:0], ccff_head};
      if (m_cnt + 1 == LOADB) begin
        m_cnt <= 0;
        m_commit <= 1'b1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // scoreboard compare, once per cycle away from the active edge
  always @(negedge prog_clk) begin
    if (cmp_on) begin
      check("chan_out", chan_out, model_route((m_commit && model_par_ok(m_shadow)) ? model_cfg(m_shadow) : m_active, chan_in));
      check("ccff_tail", ccff_tail, m_shadow[LOADB-1]);
      check("cfg_done", cfg_done, m_commit);
      check("cfg_valid", cfg_valid, m_valid);
`ifdef SB_CFG_PARITY_EN
      check("cfg_err", cfg_err, m_err);
`endif
    end
  end

  // driver tasks
  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  // Shifts a bitstream MSB first; returns in the COMMIT cycle with ccff_en low.
  task automatic load_cfg(input logic [CFGB-1:0] cfg, input int stall_at, input int stall_len,
                          input int abort_at, input bit bad_par, input bit rnd_in, input bit chk_dark);
    logic [LOADB-1:0] bits;
`ifdef SB_CFG_PARITY_EN
    bits = {cfg, (^cfg) ^ bad_par};
`else
    bits = cfg;
    if (bad_par) bits[0] = ~bits[0];
`endif
    for (int n = 0; n < LOADB; n++) begin
      if (n == abort_at) begin
        ccff_en = 1'b0;
        pReset = 1'b0;
        step();
        pReset = 1'b1;
        return;
      end
      if (n == stall_at) begin
        ccff_en = 1'b0;
        ccff_head = 1'b1;
        repeat (stall_len) begin
          if (rnd_in) chan_in = NOUT'($urandom);
          step();
        end
      end
      ccff_en = 1'b1;
      ccff_head = bits[LOADB-1-n];
      if (rnd_in) chan_in = NOUT'($urandom);
      step();
      if (chk_dark && n < LOADB - 1) check("pre_commit_dark", chan_out[0], 1'b0);
    end
    ccff_en = 1'b0;
    #1;
  endtask

  logic [CFGB-1:0] cfg_a;
  logic [CFGB-1:0] cfg_b;

  initial begin
    // 1: reset with all inputs high
    pReset = 1'b0;
    chan_in = '1;
    repeat (2) step();
    cmp_on = 1'b1;
    check("rst_chan_out", chan_out, '0);
    check("rst_tail", ccff_tail, 1'b0);
    check("rst_done", cfg_done, 1'b0);
    check("rst_valid", cfg_valid, 1'b0);
    check("rst_state", dbg_state, SB_IDLE);
    pReset = 1'b1;

    // 2: field 0 = en, sel 0 -> top t0 from right t0
    cfg_a = '0;
    cfg_a[2:0] = 3'b100;
    chan_in = '0;
    chan_in[5] = 1'b1;
    load_cfg(cfg_a, -1, 0, -1, 1'b0, 1'b0, 1'b1);
    check("t2_done", cfg_done, 1'b1);
    check("t2_out0", chan_out[0], 1'b1);
    step();
    check("t2_valid", cfg_valid, 1'b1);
    chan_in[5] = 1'b0;
    #1 check("t2_toggle_lo", chan_out[0], 1'b0);
    chan_in[5] = 1'b1;
    #1 check("t2_toggle_hi", chan_out[0], 1'b1);

    // 3: clear, then reload the same bitstream with a 7-cycle stall at bit 30
    load_cfg('0, -1, 0, -1, 1'b0, 1'b0, 1'b0);
    step();
    check("t3_cleared", chan_out[0], 1'b0);
    load_cfg(cfg_a, 30, 7, -1, 1'b0, 1'b0, 1'b1);
    check("t3_done", cfg_done, 1'b1);
    check("t3_out0", chan_out[0], 1'b1);
    step();

    // 4: left t4 with sel 3 routes from top t0; then disabled
    cfg_b = '0;
    cfg_b[19*FLD +: FLD] = 3'b111;
    chan_in = '0;
    chan_in[0] = 1'b1;
    load_cfg(cfg_b, -1, 0, -1, 1'b0, 1'b0, 1'b0);
    step();
    check("t4_out19_hi", chan_out[19], 1'b1);
    chan_in[0] = 1'b0;
    #1 check("t4_out19_lo", chan_out[19], 1'b0);
    cfg_b[19*FLD +: FLD] = 3'b011;
    load_cfg(cfg_b, -1, 0, -1, 1'b0, 1'b0, 1'b0);
    step();
    chan_in[0] = 1'b1;
    #1 check("t4_out19_dis", chan_out[19], 1'b0);

    // 5: reset at bit 40 of a reload, then a fresh load
    chan_in = '1;
    load_cfg({$urandom, $urandom}, -1, 0, 40, 1'b0, 1'b0, 1'b0);
    check("t5_chan_out", chan_out, '0);
    check("t5_valid", cfg_valid, 1'b0);
    check("t5_tail", ccff_tail, 1'b0);
    load_cfg(cfg_a, -1, 0, -1, 1'b0, 1'b0, 1'b0);
    step();
    check("t5_reload_valid", cfg_valid, 1'b1);
    check("t5_reload_out0", chan_out[0], 1'b1);

`ifdef SB_CFG_PARITY_EN
    // 6: bad parity leaves the old mapping in place
    load_cfg(cfg_b, -1, 0, -1, 1'b1, 1'b0, 1'b0);
    check("t6_done", cfg_done, 1'b1);
    step();
    check("t6_err", cfg_err, 1'b1);
    check("t6_old_map", chan_out[0], 1'b1);
    load_cfg(cfg_b, -1, 0, -1, 1'b0, 1'b0, 1'b0);
    step();
    check("t6_err_clr", cfg_err, 1'b0);
    check("t6_new_map", chan_out[0], 1'b0);
`endif

    // random loads, stalls, idle gaps and ignored bits during COMMIT
    for (int r = 0; r < 12; r++) begin
      load_cfg({$urandom, $urandom}, int'($urandom_range(0, LOADB + 5)), int'($urandom_range(1, 6)),
               -1, bit'($urandom_range(0, 3) == 0), 1'b1, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        ccff_en = 1'b1;
        ccff_head = 1'(($urandom));
      end
      step();
      ccff_en = 1'b0;
      repeat ($urandom_range(1, 5)) begin
        chan_in = NOUT'($urandom);
        step();
      end
    end

    repeat (2) step();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
